// File: rtl/decode_window_sequencer_pkg.sv
// Shared definitions for the decode window sequencer and its byte shifter.
// Window geometry, instruction length limit and the sequencer state encoding.
package decode_window_sequencer_pkg;

    localparam int WINDOW_BYTES  = 16;
    localparam int FETCH_BYTES   = 4;
    localparam int MAX_INSTR_LEN = 15;
    localparam int READY_LIMIT   = WINDOW_BYTES - FETCH_BYTES;

    typedef enum logic [1:0] {
        ST_FILL  = 2'd0,
        ST_HOLD  = 2'd1,
        ST_FAULT = 2'd2
    } seq_state_t;

    // A fetch beat only carries data when its byte count is 1..FETCH_BYTES.
    function automatic logic fetch_count_ok(input logic [2:0] count);
        return (count != 3'd0) && (count <= 3'(FETCH_BYTES));
    endfunction

endpackage

// File: rtl/decode_window_shifter.sv
// Combinational window update: drop i_shift_len oldest bytes, then append up to
// FETCH_BYTES new bytes at the resulting base; everything above the new count is zero.
module decode_window_shifter
    import decode_window_sequencer_pkg::*;
(
    input  logic [127:0] i_window,
    input  logic [4:0]   i_count,
    input  logic [3:0]   i_shift_len,
    input  logic [31:0]  i_append_data,
    input  logic [2:0]   i_append_count,
    output logic [127:0] o_window,
    output logic [4:0]   o_count
);

    logic [4:0] base;

    // Caller guarantees i_shift_len <= i_count.
    assign base    = i_count - {1'b0, i_shift_len};
    assign o_count = base + {2'b00, i_append_count};

    always_comb begin
        o_window = '0;
        for (int i = 0; i < WINDOW_BYTES; i++) begin
            if (i < int'(base)) begin
                if (i + int'(i_shift_len) < WINDOW_BYTES) begin
                    o_window[8*i +: 8] = i_window[8*(i + int'(i_shift_len)) +: 8];
                end
            end else if ((i - int'(base) < int'(i_append_count)) &&
                         (i - int'(base) < FETCH_BYTES)) begin
                o_window[8*i +: 8] = i_append_data[8*(i - int'(base)) +: 8];
            end
        end
    end

endmodule

// File: rtl/decode_window_sequencer.sv
// Owns the 16-byte decode window: appends fetch chunks, holds each decoded
// instruction until accepted, retires its bytes, and tracks a sticky fault.
module decode_window_sequencer
    import decode_window_sequencer_pkg::*;
(
    input  logic         i_clock,
    input  logic         i_reset,
    input  logic         i_flush,
    input  logic         i_fetch_valid,
    input  logic [31:0]  i_fetch_data,
    input  logic [2:0]   i_fetch_count,
    output logic         o_fetch_ready,
    output logic [127:0] o_window,
    output logic [4:0]   o_window_count,
    input  logic [3:0]   i_decode_length,
    input  logic         i_decode_error,
    output logic         o_issue_valid,
    input  logic         i_issue_ready,
    output logic [3:0]   o_issue_length,
    output logic         o_fault
);

    // Handshakes: a fetch chunk transfers on a cycle where i_fetch_valid and
    // o_fetch_ready are both high; an issued instruction transfers where
    // o_issue_valid and i_issue_ready are both high. Both are dropped on flush.

    seq_state_t   state_q, state_d;
    logic [127:0] window_q, window_d;
    logic [4:0]   count_q, count_d;
    logic [3:0]   issue_length_q, issue_length_d;

    logic         fetch_accept;
    logic         retire;
    logic         length_valid;
    logic [3:0]   shift_len;
    logic [2:0]   append_count;
    logic [127:0] shift_window;
    logic [4:0]   shift_count;

    assign o_fetch_ready  = (count_q <= 5'(READY_LIMIT)) && (state_q != ST_FAULT);
    assign o_window       = window_q;
    assign o_window_count = count_q;
    assign o_issue_valid  = (state_q == ST_HOLD);
    assign o_issue_length = issue_length_q;
    assign o_fault        = (state_q == ST_FAULT);

    assign fetch_accept = i_fetch_valid && o_fetch_ready && fetch_count_ok(i_fetch_count);
    assign retire       = (state_q == ST_HOLD) && i_issue_ready;
    assign length_valid = (i_decode_length != 4'd0) && ({1'b0, i_decode_length} <= count_q);
    assign shift_len    = retire ? issue_length_q : 4'd0;
    assign append_count = fetch_accept ? i_fetch_count : 3'd0;

    decode_window_shifter u_shifter (
        .i_window       (window_q),
        .i_count        (count_q),
        .i_shift_len    (shift_len),
        .i_append_data  (i_fetch_data),
        .i_append_count (append_count),
        .o_window       (shift_window),
        .o_count        (shift_count)
    );

    always_comb begin
        state_d        = state_q;
        issue_length_d = issue_length_q;
        window_d       = shift_window;
        count_d        = shift_count;

        case (state_q)
            ST_FILL: begin
                // A full window that still fails to decode can never make progress.
                if (count_q != 5'd0) begin
                    if (i_decode_error && ((count_q == 5'(WINDOW_BYTES)) || length_valid)) begin
                        state_d = ST_FAULT;
                    end else if (length_valid) begin
                        issue_length_d = i_decode_length;
                        state_d        = ST_HOLD;
                    end
                end
            end
            ST_HOLD: begin
                if (i_issue_ready) begin
                    state_d = ST_FILL;
                end
            end
            ST_FAULT: begin
                state_d = ST_FAULT;
            end
            default: begin
                state_d = ST_FILL;
            end
        endcase

        if (i_flush) begin
            state_d  = ST_FILL;
            window_d = '0;
            count_d  = 5'd0;
        end
    end

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            state_q        <= ST_FILL;
            window_q       <= '0;
            count_q        <= 5'd0;
            issue_length_q <= 4'd0;
        end else begin
            state_q        <= state_d;
            window_q       <= window_d;
            count_q        <= count_d;
            issue_length_q <= issue_length_d;
        end
    end

endmodule

// File: tb/tb_decode_window_sequencer.sv
// Directed bench for decode_window_sequencer: a per-cycle vector table plus
// hand-written sequences for full-window contents and reset during HOLD.
module tb_decode_window_sequencer;

    logic         clk;
    logic         rst;
    logic         flush;
    logic         fetch_valid;
    logic [31:0]  fetch_data;
    logic [2:0]   fetch_count;
    logic         fetch_ready;
    logic [127:0] window;
    logic [4:0]   window_count;
    logic [3:0]   decode_length;
    logic         decode_error;
    logic         issue_valid;
    logic         issue_ready;
    logic [3:0]   issue_length;
    logic         fault;

    int n_cmp = 0;
    int n_err = 0;
    int row   = 0;

    decode_window_sequencer dut (
        .i_clock         (clk),
        .i_reset         (rst),
        .i_flush         (flush),
        .i_fetch_valid   (fetch_valid),
        .i_fetch_data    (fetch_data),
        .i_fetch_count   (fetch_count),
        .o_fetch_ready   (fetch_ready),
        .o_window        (window),
        .o_window_count  (window_count),
        .i_decode_length (decode_length),
        .i_decode_error  (decode_error),
        .o_issue_valid   (issue_valid),
        .i_issue_ready   (issue_ready),
        .o_issue_length  (issue_length),
        .o_fault         (fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        fl;
        logic        fv;
        logic [31:0] fd;
        logic [2:0]  fc;
        logic [3:0]  dl;
        logic        de;
        logic        ir;
        logic [4:0]  e_count;
        logic        e_valid;
        logic [3:0]  e_len;
        logic        e_fault;
        logic        e_ready;
        logic [31:0] e_lo;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic fl, input logic fv, input logic [31:0] fd,
                       input logic [2:0] fc, input logic [3:0] dl, input logic de,
                       input logic ir, input logic [4:0] ec, input logic ev,
                       input logic [3:0] el, input logic ef, input logic er,
                       input logic [31:0] elo);
        vec_t v;
        v.fl = fl; v.fv = fv; v.fd = fd; v.fc = fc; v.dl = dl; v.de = de; v.ir = ir;
        v.e_count = ec; v.e_valid = ev; v.e_len = el; v.e_fault = ef; v.e_ready = er;
        v.e_lo = elo;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s (row %0d): got %h, expected %h", name, row, act, exp);
        end
    endtask

    task automatic drive(input logic fl, input logic fv, input logic [31:0] fd,
                         input logic [2:0] fc, input logic [3:0] dl, input logic de,
                         input logic ir);
        flush = fl; fetch_valid = fv; fetch_data = fd; fetch_count = fc;
        decode_length = dl; decode_error = de; issue_ready = ir;
    endtask

    task automatic check_zero_fill(input logic [4:0] exp_count);
        logic [127:0] mask;
        mask = '0;
        for (int i = 0; i < 16; i++) begin
            if (i >= int'(exp_count)) mask[8*i +: 8] = 8'hFF;
        end
        check("zero_fill", window & mask, 128'd0);
    endtask

    initial begin
        drive(0, 0, 32'h0, 3'd0, 4'd0, 0, 0);
        rst = 1'b1;

        // S1: push 4 bytes, length 2 -> issue a cycle later, retire 2
        add(0,1,32'h00C31189,4,2,0,0,  4,0,0,0,1,32'h00C31189);
        add(0,0,32'h0,0,2,0,0,         4,1,2,0,1,32'h00C31189);
        add(0,0,32'h0,0,0,0,1,         2,0,0,0,1,32'h000000C3);
        add(1,0,32'h0,0,0,0,0,         0,0,0,0,1,32'h0);
        // S2: length 6 needs a second chunk
        add(0,1,32'h44332211,4,6,0,0,  4,0,0,0,1,32'h44332211);
        add(0,0,32'h0,0,6,0,0,         4,0,0,0,1,32'h44332211);
        add(0,1,32'h88776655,4,6,0,0,  8,0,0,0,1,32'h44332211);
        add(0,0,32'h0,0,6,0,0,         8,1,6,0,1,32'h44332211);
        add(0,0,32'h0,0,0,0,1,         2,0,0,0,1,32'h00008877);
        add(1,0,32'h0,0,0,0,0,         0,0,0,0,1,32'h0);
        // S3: stall downstream for 5 cycles while appending
        add(0,1,32'hDDCCBBAA,4,3,0,0,  4,0,0,0,1,32'hDDCCBBAA);
        add(0,0,32'h0,0,3,0,0,         4,1,3,0,1,32'hDDCCBBAA);
        add(0,1,32'h04030201,4,3,0,0,  8,1,3,0,1,32'hDDCCBBAA);
        for (int k = 0; k < 4; k++)
            add(0,0,32'h0,0,5,0,0,     8,1,3,0,1,32'hDDCCBBAA);
        add(0,0,32'h0,0,0,0,1,         5,0,0,0,1,32'h030201DD);
        add(1,0,32'h0,0,0,0,0,         0,0,0,0,1,32'h0);
        // S4: fill to 16, retire with a refused push, ready returns at 12
        add(0,1,32'h03020100,4,0,0,0,  4,0,0,0,1,32'h03020100);
        add(0,1,32'h07060504,4,0,0,0,  8,0,0,0,1,32'h03020100);
        add(0,1,32'h0B0A0908,4,0,0,0, 12,0,0,0,1,32'h03020100);
        add(0,1,32'h0F0E0D0C,4,0,0,0, 16,0,0,0,0,32'h03020100);
        add(0,0,32'h0,0,3,0,0,        16,1,3,0,0,32'h03020100);
        add(0,1,32'h13121110,4,0,0,1, 13,0,0,0,0,32'h06050403);
        add(0,0,32'h0,0,1,0,0,        13,1,1,0,0,32'h06050403);
        add(0,0,32'h0,0,0,0,1,        12,0,0,0,1,32'h07060504);
        add(0,1,32'h0000AA22,2,0,0,0, 14,0,0,0,0,32'h07060504);
        add(1,0,32'h0,0,0,0,0,         0,0,0,0,1,32'h0);
        // S5: decode error on a full window -> sticky fault until flush
        add(0,1,32'h11111111,4,0,0,0,  4,0,0,0,1,32'h11111111);
        add(0,1,32'h22222222,4,0,0,0,  8,0,0,0,1,32'h11111111);
        add(0,1,32'h33333333,4,0,0,0, 12,0,0,0,1,32'h11111111);
        add(0,1,32'h44444444,4,0,0,0, 16,0,0,0,0,32'h11111111);
        add(0,0,32'h0,0,0,1,0,        16,0,0,1,0,32'h11111111);
        add(0,1,32'h55555555,4,4,0,1, 16,0,0,1,0,32'h11111111);
        add(1,0,32'h0,0,0,0,0,         0,0,0,0,1,32'h0);
        // S5b: error with a valid length faults; S5c: error with too few bytes waits
        add(0,1,32'hA1A2A3A4,4,2,1,0,  4,0,0,0,1,32'hA1A2A3A4);
        add(0,0,32'h0,0,2,1,0,         4,0,0,1,0,32'hA1A2A3A4);
        add(1,0,32'h0,0,0,0,0,         0,0,0,0,1,32'h0);
        add(0,1,32'hEEEEB2B1,2,5,1,0,  2,0,0,0,1,32'h0000B2B1);
        add(0,0,32'h0,0,5,1,0,         2,0,0,0,1,32'h0000B2B1);
        add(1,0,32'h0,0,0,0,0,         0,0,0,0,1,32'h0);
        // S6: flush beats a same-cycle issue handshake and fetch push
        add(0,1,32'h5A5A5A5A,4,2,0,0,  4,0,0,0,1,32'h5A5A5A5A);
        add(0,0,32'h0,0,2,0,0,         4,1,2,0,1,32'h5A5A5A5A);
        add(1,1,32'h66666666,4,2,0,1,  0,0,0,0,1,32'h0);
        add(0,0,32'h0,0,2,0,0,         0,0,0,0,1,32'h0);
        // S7: illegal fetch counts are ignored
        add(0,1,32'h77777777,0,0,0,0,  0,0,0,0,1,32'h0);
        add(0,1,32'h77777777,5,0,0,0,  0,0,0,0,1,32'h0);
        add(0,1,32'h77777777,7,0,0,0,  0,0,0,0,1,32'h0);
        add(0,1,32'h777777EE,1,0,0,0,  1,0,0,0,1,32'h000000EE);
        add(1,0,32'h0,0,0,0,0,         0,0,0,0,1,32'h0);

        repeat (2) @(posedge clk);
        #1;
        check("reset_count", {123'd0, window_count}, 128'd0);
        check("reset_window", window, 128'd0);
        check("reset_issue_valid", {127'd0, issue_valid}, 128'd0);
        check("reset_issue_length", {124'd0, issue_length}, 128'd0);
        check("reset_fault", {127'd0, fault}, 128'd0);
        check("reset_fetch_ready", {127'd0, fetch_ready}, 128'd1);
        rst = 1'b0;

        foreach (vecs[r]) begin
            row = r;
            drive(vecs[r].fl, vecs[r].fv, vecs[r].fd, vecs[r].fc, vecs[r].dl,
                  vecs[r].de, vecs[r].ir);
            @(posedge clk);
            #1;
            check("count", {123'd0, window_count}, {123'd0, vecs[r].e_count});
            check("issue_valid", {127'd0, issue_valid}, {127'd0, vecs[r].e_valid});
            if (vecs[r].e_valid)
                check("issue_length", {124'd0, issue_length}, {124'd0, vecs[r].e_len});
            check("fault", {127'd0, fault}, {127'd0, vecs[r].e_fault});
            check("fetch_ready", {127'd0, fetch_ready}, {127'd0, vecs[r].e_ready});
            check("window_lo", {96'd0, window[31:0]}, {96'd0, vecs[r].e_lo});
            check_zero_fill(vecs[r].e_count);
        end

        // Full 16-byte window contents after four pushes.
        row = 1000;
        for (int k = 0; k < 4; k++) begin
            drive(0, 1, {8'(4*k+3), 8'(4*k+2), 8'(4*k+1), 8'(4*k)}, 3'd4, 4'd0, 0, 0);
            @(posedge clk);
            #1;
        end
        check("full_window", window, 128'h0F0E0D0C_0B0A0908_07060504_03020100);
        check("full_count", {123'd0, window_count}, 128'd16);

        // Reach HOLD with length 4, then reset mid-cycle with no handshake.
        row = 1001;
        drive(0, 0, 32'h0, 3'd0, 4'd4, 0, 0);
        @(posedge clk);
        #1;
        check("hold_valid", {127'd0, issue_valid}, 128'd1);
        check("hold_length", {124'd0, issue_length}, 128'd4);
        #3;
        rst = 1'b1;
        #1;
        check("async_reset_valid", {127'd0, issue_valid}, 128'd0);
        check("async_reset_length", {124'd0, issue_length}, 128'd0);
        check("async_reset_count", {123'd0, window_count}, 128'd0);
        check("async_reset_window", window, 128'd0);
        check("async_reset_ready", {127'd0, fetch_ready}, 128'd1);
        @(posedge clk);
        #1;
        rst = 1'b0;
        drive(0, 0, 32'h0, 3'd0, 4'd0, 0, 0);
        @(posedge clk);
        #1;
        check("post_reset_valid", {127'd0, issue_valid}, 128'd0);
        check("post_reset_count", {123'd0, window_count}, 128'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
